// File: rtl/abs_dif_acc.sv
// abs_dif_acc: flag-steered |a-b| followed by a block sum-of-absolute-differences over LEN samples.
// Define ABS_DIF_ACC_MAX_EN to add out_max, the largest |a-b| seen in each block.
module abs_dif_acc #(
  parameter int N   = 4,
  parameter int LEN = 8,
  parameter int SW  = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          agb,
  input  logic          aeb,
  input  logic          alb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
`ifdef ABS_DIF_ACC_MAX_EN
  output logic [N-1:0]  out_max,
`endif
  output logic          err
);
  localparam int CW = $clog2(LEN);

  typedef enum logic {RUN, DONE} state_t;
  state_t state, state_nxt;

  logic          vld_p1;
  logic [N-1:0]  d1_p1;
  logic [SW-1:0] acc_p2;
  logic [CW-1:0] cnt_p2;
  logic          accept, s2_take, out_take, last;

  function automatic logic flags_bad(input logic g, input logic e, input logic l);
    flags_bad = !(({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) || ({g, e, l} == 3'b001));
  endfunction

  // The comparator flags pick the operand order, so the N-bit subtraction never wraps.
  function automatic logic [N-1:0] abs_dif(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic g, input logic e, input logic l);
    case ({g, e, l})
      3'b100:  abs_dif = x - y;
      3'b001:  abs_dif = y - x;
      default: abs_dif = '0;
    endcase
  endfunction

  assign s2_take  = vld_p1 && (state == RUN);
  assign in_ready = !rst && (!vld_p1 || s2_take);
  assign accept   = in_valid && in_ready;
  assign out_take = out_valid && out_ready;
  assign last     = (cnt_p2 == CW'(LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (s2_take && last) state_nxt = DONE;
      DONE:    if (out_take) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Stage 1: capture |a-b| on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (accept)       vld_p1 <= 1'b1;
      else if (s2_take) vld_p1 <= 1'b0;
      if (accept && flags_bad(agb, aeb, alb)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) d1_p1 <= abs_dif(a, b, agb, aeb, alb);
  end

  // Stage 2: accumulate and close the block
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2    <= '0;
      cnt_p2    <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else if (s2_take) begin
      if (last) begin
        out_sum   <= acc_p2 + SW'(d1_p1);
        out_valid <= 1'b1;
        acc_p2    <= '0;
        cnt_p2    <= '0;
      end else begin
        acc_p2 <= acc_p2 + SW'(d1_p1);
        cnt_p2 <= cnt_p2 + CW'(1);
      end
    end else if (out_take) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ABS_DIF_ACC_MAX_EN
  logic [N-1:0] mx_p2, mx_nxt;

  assign mx_nxt = (d1_p1 > mx_p2) ? d1_p1 : mx_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      mx_p2   <= '0;
      out_max <= '0;
    end else if (s2_take) begin
      if (last) begin
        out_max <= mx_nxt;
        mx_p2   <= '0;
      end else begin
        mx_p2 <= mx_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_abs_dif_acc.sv
// Self-checking bench for abs_dif_acc: directed test-plan blocks plus a randomized stream
// checked against a queue-based model of accepted samples.
module tb_abs_dif_acc;
  localparam int N   = 4;
  localparam int LEN = 8;
  localparam int SW  = 7;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, agb, aeb, alb;
  logic          out_valid, out_ready, err;
  logic [N-1:0]  a, b;
  logic [SW-1:0] out_sum;
`ifdef ABS_DIF_ACC_MAX_EN
  logic [N-1:0]  out_max;
  int            last_max;
`endif

  always #5 clk = ~clk;

  abs_dif_acc #(.N(N), .LEN(LEN), .SW(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .agb(agb), .aeb(aeb), .alb(alb),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef ABS_DIF_ACC_MAX_EN
    .out_max(out_max),
`endif
    .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int d_q[$];
  bit err_m;
  bit last_acc;
  int last_sum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit one_hot(input bit g, input bit e, input bit l);
    return (int'(g) + int'(e) + int'(l)) == 1;
  endfunction

  // Flag-steered difference, modulo 2^N; illegal combinations contribute zero.
  function automatic int ref_d(input int av, input int bv, input bit g, input bit e, input bit l);
    int m = 1 << N;
    if (!one_hot(g, e, l)) return 0;
    if (g) return ((av - bv) % m + m) % m;
    if (l) return ((bv - av) % m + m) % m;
    return 0;
  endfunction

  task automatic check_block();
    int s = 0;
    int mx = 0;
    if (d_q.size() < LEN) begin
      check("block_underflow", d_q.size(), LEN);
      return;
    end
    for (int i = 0; i < LEN; i++) begin
      int v = d_q.pop_front();
      s += v;
      if (v > mx) mx = v;
    end
    check("out_sum", out_sum, s);
    last_sum = int'(out_sum);
`ifdef ABS_DIF_ACC_MAX_EN
    check("out_max", out_max, mx);
    last_max = int'(out_max);
`endif
  endtask

  // One clock: sample handshakes mid-cycle, advance, then update model and check state.
  task automatic cycle();
    bit acc_s, take_s, hold_s, rst_s, bad;
    int d;
    logic [SW-1:0] sum_s;
    #1;
    rst_s  = rst;
    acc_s  = in_valid && in_ready;
    take_s = out_valid && out_ready;
    hold_s = out_valid && !out_ready;
    sum_s  = out_sum;
    d      = ref_d(int'(a), int'(b), agb, aeb, alb);
    bad    = !one_hot(agb, aeb, alb);
    if (rst_s) check("in_ready_rst", in_ready, 0);
    else if (take_s) check_block();
    @(posedge clk);
    #1;
    last_acc = acc_s && !rst_s;
    if (rst_s) begin
      d_q.delete();
      err_m = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_err", err, 0);
      return;
    end
    if (acc_s) begin
      d_q.push_back(d);
      if (bad) err_m = 1;
    end
    check("err", err, err_m);
    if (hold_s) begin
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, sum_s);
    end
  endtask

  task automatic send(input int av, input int bv, input bit g, input bit e, input bit l);
    int k = 0;
    a = N'(av); b = N'(bv); agb = g; aeb = e; alb = l; in_valid = 1'b1;
    do begin cycle(); k++; end while (!last_acc && k < 100);
    if (!last_acc) check("send_timeout", 0, 1);
  endtask

  task automatic send_cmp(input int av, input int bv);
    send(av, bv, av > bv, av == bv, av < bv);
  endtask

  task automatic rand_inputs(input bit allow_bad);
    logic [2:0] f;
    a = N'($urandom); b = N'($urandom);
    agb = a > b; aeb = a == b; alb = a < b;
    if (allow_bad && $urandom_range(15) == 0) begin
      do f = 3'($urandom); while ($countones(f) == 1);
      {agb, aeb, alb} = f;
    end
  endtask

  task automatic drain();
    int k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((d_q.size() >= LEN || out_valid) && k < 60) begin cycle(); k++; end
    check("drain_done", (d_q.size() >= LEN || out_valid) ? 1 : 0, 0);
  endtask

  // Keep feeding until the model holds a whole number of blocks, then empty the pipe.
  task automatic finish_blocks(input bit allow_bad);
    int k = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while ((d_q.size() % LEN) != 0 && k < 200) begin
      cycle();
      if (last_acc) rand_inputs(allow_bad);
      k++;
    end
    drain();
    check("no_loss", d_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; agb = 1'b0; aeb = 1'b1; alb = 1'b0;
    err_m = 0; last_sum = -1;
    cycle(); cycle();
    rst = 1'b0;

    // Uniform block with exact output timing
    for (int i = 0; i < LEN; i++) send_cmp(9, 3);
    in_valid = 1'b0;
    check("t1_valid_early", out_valid, 0);
    cycle();
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 48);
    check("t1_err", err, 0);
    cycle();
    check("t1_pulse", out_valid, 0);
    drain();

    // Mixed flags
    send_cmp(15, 0); send_cmp(0, 15); send_cmp(7, 7); send_cmp(5, 12);
    send_cmp(12, 5); send_cmp(1, 0);  send_cmp(0, 1); send_cmp(8, 8);
    drain();
    check("mixed_sum", last_sum, 46);

    // Back-pressure: stall the output for 6 cycles while the input keeps offering
    out_ready = 1'b0; in_valid = 1'b1; rand_inputs(0);
    k = 0;
    while (!out_valid && k < 100) begin
      cycle();
      if (last_acc) rand_inputs(0);
      k++;
    end
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_acc) rand_inputs(0);
    end
    check("bp_in_ready", in_ready, 0);
    finish_blocks(0);

    // Illegal flag combination on sample 3
    send_cmp(4, 1); send_cmp(4, 1);
    send(10, 2, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_cmp(4, 1);
    drain();
    check("illegal_sum", last_sum, 21);
    check("illegal_err", err, 1);
    for (int i = 0; i < LEN; i++) send_cmp(4, 1);
    drain();
    check("illegal_err_sticky", err, 1);
    check("legal_after_sum", last_sum, 24);

    // Reset mid-block
    for (int i = 0; i < 3; i++) send_cmp(6, 1);
    in_valid = 1'b0;
    cycle();
    check("rst_no_out", out_valid, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < LEN; i++) send_cmp(2, 0);
    drain();
    check("rst_first_sum", last_sum, 16);

    // Full-scale block
    for (int i = 0; i < LEN; i++) send_cmp(15, 0);
    drain();
    check("max_sum", last_sum, 120);
`ifdef ABS_DIF_ACC_MAX_EN
    check("max_val", last_max, 15);
`endif

    // Randomized stream with random valid/ready and occasional illegal flags
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      rand_inputs(1);
      cycle();
    end
    finish_blocks(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
